// File: rtl/popup_dialog.sv
// Modal option dialog: opens on activate, navigates with up/down, closes on select or back.
// Define POPUP_DIALOG_TIMEOUT_EN to compile in the idle auto-cancel counter.
module popup_dialog #(
  parameter int NUM_OPTIONS    = 2,
  parameter int MSG_W          = 16,
  parameter int DEFAULT_OPT    = 0,
  parameter int WRAP           = 1,
  parameter int TIMEOUT_CYCLES = 50000000,
  localparam int CW = ($clog2(NUM_OPTIONS) < 1) ? 1 : $clog2(NUM_OPTIONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             activate,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  input  logic             btn_back,
  input  logic [MSG_W-1:0] msg_in,
  output logic             active,
  output logic [CW-1:0]    cursor,
  output logic [MSG_W-1:0] msg_out,
  output logic             confirmed,
  output logic [CW-1:0]    choice,
  output logic             canceled,
  output logic             timed_out
);

  localparam logic [CW-1:0] LAST = CW'(NUM_OPTIONS - 1);
  localparam logic [CW-1:0] DEF  = CW'(DEFAULT_OPT);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cursor_q, cursor_d;
  logic [CW-1:0]    choice_q, choice_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             conf_q, conf_d;
  logic             canc_q, canc_d;
  logic [3:0]       prev_q;
  logic [3:0]       btn, press;
  logic             tmo_close;

  // Bit order: {back, sel, down, up}
  assign btn   = {btn_back, btn_sel, btn_down, btn_up};
  assign press = btn & ~prev_q;

`ifdef POPUP_DIALOG_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES);
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tmo_q;

  // Counter only runs while open with no press, so it restarts at 0 on every open.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_ACTIVE && !(|press)) cnt_d = cnt_q + 1'b1;
  end

  assign tmo_close = (state_q == S_ACTIVE) && !(|press) &&
                     (cnt_q == CNTW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_close;
    end
  end

  assign timed_out = tmo_q;
`else
  assign tmo_close = 1'b0;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cursor_q <= DEF;
      choice_q <= '0;
      msg_q    <= '0;
      conf_q   <= 1'b0;
      canc_q   <= 1'b0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      choice_q <= choice_d;
      msg_q    <= msg_d;
      conf_q   <= conf_d;
      canc_q   <= canc_d;
      prev_q   <= btn;
    end
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    choice_d = choice_q;
    msg_d    = msg_q;
    conf_d   = 1'b0;
    canc_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (activate) begin
          state_d  = S_ACTIVE;
          cursor_d = DEF;
          msg_d    = msg_in;
        end
      end
      S_ACTIVE: begin
        if (press[3] || tmo_close) begin
          state_d = S_DONE;
          canc_d  = 1'b1;
        end else if (press[2]) begin
          state_d  = S_DONE;
          conf_d   = 1'b1;
          choice_d = cursor_q;
        end else if (press[0] && !press[1]) begin
          if (cursor_q == '0) cursor_d = (WRAP != 0) ? LAST : '0;
          else                cursor_d = cursor_q - 1'b1;
        end else if (press[1] && !press[0]) begin
          if (cursor_q == LAST) cursor_d = (WRAP != 0) ? '0 : LAST;
          else                  cursor_d = cursor_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign active    = (state_q == S_ACTIVE);
  assign cursor    = cursor_q;
  assign msg_out   = msg_q;
  assign confirmed = conf_q;
  assign choice    = choice_q;
  assign canceled  = canc_q;

endmodule
